// File: rtl/uart_tx_feeder_pkg.sv
// uart_tx_feeder_pkg: shared UART data width and the feeder launch FSM encoding
package uart_tx_feeder_pkg;
  localparam int UART_DATA_W = 8;
  typedef enum logic [1:0] {
    FEED_IDLE    = 2'd0,
    FEED_START   = 2'd1,
    FEED_WAIT_HI = 2'd2,
    FEED_WAIT_LO = 2'd3
  } feed_state_e;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with occupancy count and a combinational head read
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wr_data,
  output logic [W-1:0]  rd_data,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  assign count = count_q;
  assign empty = count_q == '0;
  assign full = count_q == (AW+1)'(DEPTH);
  assign rd_data = mem_q[rd_ptr_q];
  always_comb begin
    do_push = push && !full;
    do_pop = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers producer bytes and launches them into uart_tx one frame at a time
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [UART_DATA_W-1:0] tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic [ADDR_W:0]        fifo_count,
  output logic                   fifo_empty,
  output logic                   fifo_full,
  output logic                   overflow,
  input  logic                   ovf_clear
);
  feed_state_e state_q, state_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d, head;
  logic tx_start_q, tx_start_d, overflow_q, overflow_d, pop;
  assign wr_ready = !fifo_full;
  assign tx_data = tx_data_q;
  assign tx_start = tx_start_q;
  assign overflow = overflow_q;
  uart_sync_fifo #(.DEPTH(DEPTH), .W(UART_DATA_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(wr_valid && wr_ready),
    .pop(pop),
    .wr_data(wr_data),
    .rd_data(head),
    .count(fifo_count),
    .empty(fifo_empty),
    .full(fifo_full)
  );
  // tx_busy is ignored in START to cover the one-cycle lag before uart_tx raises it
  always_comb begin
    state_d = state_q;
    tx_start_d = 1'b0;
    tx_data_d = tx_data_q;
    pop = 1'b0;
    case (state_q)
      FEED_IDLE: if (!fifo_empty && !tx_busy) begin
        state_d = FEED_START;
        tx_start_d = 1'b1;
        tx_data_d = head;
        pop = 1'b1;
      end
      FEED_START: state_d = FEED_WAIT_HI;
      FEED_WAIT_HI: state_d = tx_busy ? FEED_WAIT_LO : FEED_WAIT_HI;
      default: state_d = tx_busy ? FEED_WAIT_LO : FEED_IDLE;
    endcase
    overflow_d = (wr_valid && !wr_ready) ? 1'b1 : ovf_clear ? 1'b0 : overflow_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FEED_IDLE;
      tx_data_q <= '0;
      tx_start_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_data_q <= tx_data_d;
      tx_start_q <= tx_start_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: scoreboard bench with a behavioural uart_tx model and serial-line decoder
module tb_uart_tx_feeder;
  localparam int CPB = 4;
  localparam int AW = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] wr_data = '0;
  logic wr_valid = 1'b0, ovf_clear = 1'b0, hold_busy = 1'b0;
  logic wr_ready, tx_start, tx_busy, fifo_empty, fifo_full, overflow;
  logic [7:0] tx_data;
  logic [AW:0] fifo_count;
  logic m_busy, line, pend;
  logic [7:0] sh;
  int late = 0, dly, ck, bi;
  int checks = 0, errors = 0, pulses = 0, cyc = 0, p0;
  bit period_chk = 0;
  logic [7:0] start_q[$], ser_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign tx_busy = m_busy | hold_busy;

  uart_tx_feeder #(.DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .fifo_count(fifo_count),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .overflow(overflow), .ovf_clear(ovf_clear)
  );

  // uart_tx model: 1 start, 8 data LSB-first, 1 stop; busy can be delayed by 'late' cycles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; line <= 1; pend <= 0; dly <= 0; ck <= 0; bi <= 0; sh <= 0;
    end else if (pend) begin
      if (dly == 0) begin pend <= 0; m_busy <= 1; line <= 0; ck <= 0; bi <= 0; end
      else dly <= dly - 1;
    end else if (!m_busy && tx_start) begin
      sh <= tx_data;
      if (late == 0) begin m_busy <= 1; line <= 0; ck <= 0; bi <= 0; end
      else begin pend <= 1; dly <= late - 1; end
    end else if (m_busy) begin
      if (ck == CPB - 1) begin
        ck <= 0;
        if (bi == 9) m_busy <= 0;
        else begin bi <= bi + 1; line <= (bi < 8) ? sh[bi] : 1'b1; end
      end else ck <= ck + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] d);
    int n = 0;
    wr_data = d;
    wr_valid = 1;
    while (!wr_ready && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) chk("push_timeout", n, 0);
    else begin start_q.push_back(d); ser_q.push_back(d); end
    @(posedge clk); #1;
    wr_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((start_q.size() != 0 || ser_q.size() != 0 || !fifo_empty || tx_busy) && n < 6000) begin
      @(negedge clk); n++;
    end
    chk("drain_in_time", int'(n < 6000), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, fifo_count, 0);
    chk({tag, "_empty"}, fifo_empty, 1);
    chk({tag, "_full"}, fifo_full, 0);
    chk({tag, "_wr_ready"}, wr_ready, 1);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin : mon_start
    logic prev;
    prev = 0;
    forever begin
      @(negedge clk);
      if (rst_n && tx_start) begin
        pulses++;
        chk("start_width", prev, 0);
        if (start_q.size() == 0) chk("spurious_start", 1, 0);
        else chk("start_data", tx_data, start_q.pop_front());
      end
      prev = rst_n && tx_start;
    end
  end

  initial begin : mon_ser
    logic lp, ab;
    logic [7:0] b;
    int last;
    lp = 1; last = -1; b = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin lp = 1; last = -1; end
      else if (lp && !line) begin
        if (period_chk && last >= 0) chk("frame_period", cyc - last, 10 * CPB + 3);
        last = period_chk ? cyc : -1;
        ab = 0;
        for (int k = 1; k <= 38 && !ab; k++) begin
          @(negedge clk);
          if (!rst_n) ab = 1;
          else if (k == 2) chk("start_bit", line, 0);
          else if (k == 38) chk("stop_bit", line, 1);
          else if (k >= 6 && (k - 2) % 4 == 0) b[(k - 6) / 4] = line;
        end
        if (ab) last = -1;
        else if (ser_q.size() == 0) chk("spurious_frame", 1, 0);
        else chk("serial_byte", b, ser_q.pop_front());
        lp = line;
      end else lp = line;
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk); #1;
    chk_reset_vals("reset");
    rst_n = 1;
    // single byte: launch latency and one pulse
    @(negedge clk);
    wr_data = 8'hA5; wr_valid = 1; start_q.push_back(8'hA5); ser_q.push_back(8'hA5);
    @(posedge clk); #1; wr_valid = 0;
    chk("empty_after_push", fifo_empty, 0);
    chk("start_not_yet", tx_start, 0);
    @(posedge clk); #1; chk("start_k1", tx_start, 1);
    @(posedge clk); #1; chk("start_drop", tx_start, 0);
    drain();
    chk("single_pulses", pulses, 1);
    chk("single_empty", fifo_empty, 1);
    // burst to full, then overflow with 0xEE
    hold_busy = 1; period_chk = 1;
    for (int i = 1; i <= 16; i++) push(8'(i));
    chk("burst_full", fifo_full, 1);
    chk("burst_count", fifo_count, 16);
    chk("burst_no_ovf", overflow, 0);
    chk("burst_not_ready", wr_ready, 0);
    @(negedge clk); wr_data = 8'hEE; wr_valid = 1;
    repeat (3) @(posedge clk); #1; wr_valid = 0;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", fifo_count, 16);
    @(negedge clk); wr_valid = 1; ovf_clear = 1;
    @(posedge clk); #1; wr_valid = 0;
    chk("ovf_set_wins", overflow, 1);
    @(posedge clk); #1; ovf_clear = 0;
    chk("ovf_cleared", overflow, 0);
    hold_busy = 0;
    drain();
    period_chk = 0;
    chk("burst_pulses", pulses, 17);
    // simultaneous push/pop at count 5, then 40-byte stream through the ring
    hold_busy = 1;
    for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
    chk("count5", fifo_count, 5);
    @(negedge clk);
    hold_busy = 0; wr_data = 8'h45; wr_valid = 1; start_q.push_back(8'h45); ser_q.push_back(8'h45);
    @(posedge clk); #1; wr_valid = 0;
    chk("pushpop_count", fifo_count, 5);
    chk("pushpop_start", tx_start, 1);
    for (int i = 6; i < 40; i++) push(8'h40 + 8'(i));
    drain();
    chk("stream_pulses", pulses, 57);
    // reset during data bit 3 with 4 bytes queued
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
    n = 0;
    while (line && n < 200) begin @(negedge clk); n++; end
    chk("frame_began", int'(n < 200), 1);
    repeat (17) @(negedge clk);
    chk("queued4", fifo_count, 4);
    #2 rst_n = 0;
    #1 chk_reset_vals("midreset");
    start_q.delete(); ser_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    p0 = pulses;
    repeat (100) @(negedge clk);
    chk("no_start_after_reset", pulses, p0);
    chk("empty_after_reset", fifo_empty, 1);
    // late busy from the transmitter model
    late = 3;
    push(8'h3C); push(8'hC3);
    drain();
    chk("late_pulses", pulses, p0 + 2);
    late = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
